// File: rtl/i2c_reg_target.sv
// I2C target exposing a 2^PTR_W-byte register space via a pointer with auto-increment.
// Latency: 3 clk pin-to-detect; sda_oe moves 1 clk after a detected SCL fall; wr_en 1 clk after bit 0.
// Backpressure: none; the target never stretches SCL and always ACKs write bytes.
module i2c_reg_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         PTR_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic             busy,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic [PTR_W-1:0] rd_addr,
    input  logic [7:0]       rd_data
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
    } state_t;

    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    logic             scl_s1, scl_s2, scl_d;
    logic             sda_s1, sda_s2, sda_d;
    state_t           state;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic [PTR_W-1:0] ptr;
    logic             ptr_byte;   // next completed write byte loads the pointer
    logic             inc_pend;   // pointer bump owed one cycle after a write strobe
    logic             byte_done;  // phase flag: byte/ack clock seen, act on next fall
    logic             rx_nack;

    logic             scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]       shift_in;

    // Two-flop synchronizer plus one history stage for edge detection; bus idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
            sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
        end else begin
            scl_s1 <= scl_in; scl_s2 <= scl_s1; scl_d <= scl_s2;
            sda_s1 <= sda_in; sda_s2 <= sda_s1; sda_d <= sda_s2;
        end
    end

    // START/STOP only count while SCL is steadily high, so a coincident SCL edge wins.
    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & ~sda_s2 & sda_d;
    assign stop_det  = scl_s2 & scl_d & sda_s2 & ~sda_d;
    assign shift_in  = {shreg[6:0], sda_s2};
    assign rd_addr   = ptr;

    // Protocol FSM with registered SDA drive, busy flag, write strobe and pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            ptr       <= '0;
            ptr_byte  <= 1'b0;
            inc_pend  <= 1'b0;
            byte_done <= 1'b0;
            rx_nack   <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'h00;
        end else begin
            wr_en <= 1'b0;
            if (inc_pend) begin
                ptr      <= ptr + PTR_ONE;
                inc_pend <= 1'b0;
            end
            if (stop_det) begin
                state     <= IDLE;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                byte_done <= 1'b0;
            end else if (start_det) begin
                // Partial bytes are dropped; pointer is kept for combined transfers.
                state     <= ADDR;
                bit_cnt   <= 3'd0;
                byte_done <= 1'b0;
                sda_oe    <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise && !byte_done) begin
                            shreg   <= shift_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) byte_done <= 1'b1;
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            if (shreg[7:1] == TARGET_ADDR) begin
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                state  <= ADDR_ACK;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 3'd0;
                            if (shreg[0]) begin
                                shreg  <= rd_data;
                                sda_oe <= ~rd_data[7];
                                state  <= RD_BYTE;
                            end else begin
                                sda_oe   <= 1'b0;
                                ptr_byte <= 1'b1;
                                state    <= WR_BYTE;
                            end
                        end
                    end
                    WR_BYTE: begin
                        if (scl_rise) begin
                            shreg   <= shift_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (ptr_byte) begin
                                    ptr      <= shift_in[PTR_W-1:0];
                                    ptr_byte <= 1'b0;
                                end else begin
                                    wr_en    <= 1'b1;
                                    wr_addr  <= ptr;
                                    wr_data  <= shift_in;
                                    inc_pend <= 1'b1;
                                end
                                byte_done <= 1'b0;
                                state     <= WR_ACK;
                            end
                        end
                    end
                    WR_ACK: begin
                        // First fall drives ACK, second fall releases it.
                        if (scl_fall) begin
                            if (!byte_done) begin
                                sda_oe    <= 1'b1;
                                byte_done <= 1'b1;
                            end else begin
                                sda_oe    <= 1'b0;
                                byte_done <= 1'b0;
                                bit_cnt   <= 3'd0;
                                state     <= WR_BYTE;
                            end
                        end
                    end
                    RD_BYTE: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) byte_done <= 1'b1;
                        end else if (scl_fall) begin
                            if (byte_done) begin
                                sda_oe    <= 1'b0;
                                byte_done <= 1'b0;
                                state     <= RD_ACK;
                            end else begin
                                shreg  <= {shreg[6:0], 1'b0};
                                sda_oe <= ~shreg[6];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            rx_nack   <= sda_s2;
                            ptr       <= ptr + PTR_ONE;
                            byte_done <= 1'b1;
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            if (!rx_nack) begin
                                shreg   <= rd_data;
                                sda_oe  <= ~rd_data[7];
                                bit_cnt <= 3'd0;
                                state   <= RD_BYTE;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: a bit-banged controller drives the open-drain bus.
// Each bus phase is 5-10 clk, comfortably above the target's sampling requirements.
// Register model returns {4'hC, rd_addr}; write strobes are logged for checking.
module tb_i2c_reg_target;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_oe, busy, wr_en;
    logic [3:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data;
    logic       sda_bus;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int oe_cnt = 0;
    int busy_cnt = 0;
    logic [3:0] wr_addr_log [64];
    logic [7:0] wr_data_log [64];

    assign sda_bus = sda_m & ~sda_oe;
    assign rd_data = {4'hC, rd_addr};

    i2c_reg_target #(.TARGET_ADDR(7'h50), .PTR_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .scl_in  (scl_m),
        .sda_in  (sda_bus),
        .sda_oe  (sda_oe),
        .busy    (busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    // Monitor on the inactive edge: log write strobes and count SDA drive / busy cycles.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                wr_addr_log[wr_cnt] = wr_addr;
                wr_data_log[wr_cnt] = wr_data;
                wr_cnt++;
            end
            if (sda_oe) oe_cnt++;
            if (busy) busy_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(5);
        scl_m = 1'b1; tick(10);
        sda_m = 1'b0; tick(10);
        scl_m = 1'b0; tick(5);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(5);
        scl_m = 1'b1; tick(10);
        sda_m = 1'b1; tick(10);
    endtask

    task automatic xfer_bit(input logic b, output logic r);
        sda_m = b;    tick(5);
        scl_m = 1'b1; tick(5);
        r = sda_bus;  tick(5);
        scl_m = 1'b0; tick(5);
    endtask

    // Returns 1 when the target ACKed (pulled SDA low in the ninth clock).
    task automatic send_byte(input logic [7:0] b, output logic acked);
        logic r;
        for (int i = 7; i >= 0; i--) xfer_bit(b[i], r);
        xfer_bit(1'b1, r);
        acked = ~r;
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b1, r);
            b[i] = r;
        end
        xfer_bit(nack, r);
    endtask

    initial begin
        logic       ack;
        logic       r;
        logic [7:0] rb;
        int         wr0, oe0, busy0;

        // Reset values
        tick(4);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_rd_addr", rd_addr, 0);
        rst = 1'b0;
        tick(10);

        // Write: pointer 3, data A5 -> 3, 3C -> 4
        bus_start();
        send_byte(8'hA0, ack); chk("wr_ack_addr", ack, 1);
        chk("wr_busy_during", busy, 1);
        send_byte(8'h03, ack); chk("wr_ack_ptr", ack, 1);
        send_byte(8'hA5, ack); chk("wr_ack_d0", ack, 1);
        send_byte(8'h3C, ack); chk("wr_ack_d1", ack, 1);
        bus_stop();
        chk("wr_count", wr_cnt, 2);
        chk("wr0_addr", wr_addr_log[0], 4'h3);
        chk("wr0_data", wr_data_log[0], 8'hA5);
        chk("wr1_addr", wr_addr_log[1], 4'h4);
        chk("wr1_data", wr_data_log[1], 8'h3C);
        chk("wr_rd_addr", rd_addr, 4'h5);
        chk("wr_busy_after", busy, 0);

        // Combined read from pointer 5
        bus_start();
        send_byte(8'hA0, ack); chk("rd_ack_waddr", ack, 1);
        send_byte(8'h05, ack); chk("rd_ack_ptr", ack, 1);
        bus_start();
        send_byte(8'hA1, ack); chk("rd_ack_raddr", ack, 1);
        recv_byte(1'b0, rb);   chk("rd_byte0", rb, 8'hC5);
        recv_byte(1'b1, rb);   chk("rd_byte1", rb, 8'hC6);
        bus_stop();
        chk("rd_ptr", rd_addr, 4'h7);
        chk("rd_no_write", wr_cnt, 2);
        chk("rd_busy_after", busy, 0);

        // Address mismatch
        wr0 = wr_cnt; oe0 = oe_cnt; busy0 = busy_cnt;
        bus_start();
        send_byte(8'hA2, ack); chk("mm_nack_addr", ack, 0);
        send_byte(8'h11, ack); chk("mm_nack_data", ack, 0);
        bus_stop();
        chk("mm_oe_never", oe_cnt - oe0, 0);
        chk("mm_busy_never", busy_cnt - busy0, 0);
        chk("mm_no_write", wr_cnt - wr0, 0);
        chk("mm_ptr", rd_addr, 4'h7);

        // Pointer wrap: pointer F, data 11 -> F, 22 -> 0
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(8'h0F, ack);
        send_byte(8'h11, ack); chk("wrap_ack_d0", ack, 1);
        send_byte(8'h22, ack); chk("wrap_ack_d1", ack, 1);
        bus_stop();
        chk("wrap_count", wr_cnt, 4);
        chk("wrap0_addr", wr_addr_log[2], 4'hF);
        chk("wrap0_data", wr_data_log[2], 8'h11);
        chk("wrap1_addr", wr_addr_log[3], 4'h0);
        chk("wrap1_data", wr_data_log[3], 8'h22);
        chk("wrap_ptr", rd_addr, 4'h1);

        // Abort: pointer 2, then STOP after 4 data bits
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(8'h02, ack);
        xfer_bit(1'b1, r); xfer_bit(1'b0, r); xfer_bit(1'b1, r); xfer_bit(1'b0, r);
        bus_stop();
        chk("abort_no_write", wr_cnt, 4);
        chk("abort_ptr", rd_addr, 4'h2);
        chk("abort_busy", busy, 0);
        chk("abort_sda_oe", sda_oe, 0);

        // Reset while driving a read bit: C2 = 1100_0010, third bit is 0
        bus_start();
        send_byte(8'hA1, ack); chk("rst_rd_ack", ack, 1);
        xfer_bit(1'b1, r); chk("rst_rd_bit7", r, 1);
        xfer_bit(1'b1, r); chk("rst_rd_bit6", r, 1);
        chk("rst_pre_oe", sda_oe, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_sda_oe", sda_oe, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_wr_en", wr_en, 0);
        chk("rst_mid_wr_addr", wr_addr, 0);
        chk("rst_mid_wr_data", wr_data, 0);
        chk("rst_mid_rd_addr", rd_addr, 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
